adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 179 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one 32-bit adder through an IDLE/EXEC/RESP
// FSM. Priority alternates after every served operation so neither side starves.
// Optional feature: define ADDER_ARBITER_SUB_EN to add req0_sub/req1_sub inputs,
// which turn a request into a-b (computed as a + ~b + 1).
`timescale 1ns/1ps

module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    // 33-bit add so the carry-out falls out as the top bit.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    end
endmodule

module adder_arbiter #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_cin,
`ifdef ADDER_ARBITER_SUB_EN
    input  logic        req0_sub,
`endif
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_cin,
`ifdef ADDER_ARBITER_SUB_EN
    input  logic        req1_sub,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_sum,
    output logic        resp_cout
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    // Holds off any grant until the first clock edge after reset release.
    logic        started_q;

    logic [31:0] op_a_q, op_b_q;
    logic        op_cin_q, op_id_q;
    logic [31:0] resp_sum_q;
    logic        resp_cout_q, resp_id_q;

    logic        grant;
    logic        can_grant;
    logic        accept;
    logic [31:0] sel_a, sel_b;
    logic        sel_cin, sel_sub;
    logic [31:0] add_sum;
    logic        add_cout;

    // Grant: sole valid requester wins, otherwise the one holding priority.
    always_comb begin
        grant = prio_q;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign can_grant  = started_q && (state_q == StIdle);
    assign req0_ready = can_grant && req0_valid && !grant;
    assign req1_ready = can_grant && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    // Operand mux for the granted requester; subtraction folds into ~b with cin forced.
    always_comb begin
        sel_a   = grant ? req1_a   : req0_a;
        sel_b   = grant ? req1_b   : req0_b;
        sel_cin = grant ? req1_cin : req0_cin;
`ifdef ADDER_ARBITER_SUB_EN
        sel_sub = grant ? req1_sub : req0_sub;
`else
        sel_sub = 1'b0;
`endif
        if (sel_sub) begin
            sel_b   = ~sel_b;
            sel_cin = 1'b1;
        end
    end

    // The single shared adder only ever sees registered operands.
    adder_32 u_adder (
        .a    (op_a_q),
        .b    (op_b_q),
        .cin  (op_cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state and priority update.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                    prio_d  = ~resp_id_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, priority and start-up gate registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            prio_q    <= PRIO_INIT;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            started_q <= 1'b1;
        end
    end

    // Capture operands, carry-in and requester id on the accept handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_cin_q <= 1'b0;
            op_id_q  <= 1'b0;
        end else if (accept) begin
            op_a_q   <= sel_a;
            op_b_q   <= sel_b;
            op_cin_q <= sel_cin;
            op_id_q  <= grant;
        end
    end

    // Register the adder result at the end of EXEC; held stable through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sum_q  <= '0;
            resp_cout_q <= 1'b0;
            resp_id_q   <= 1'b0;
        end else if (state_q == StExec) begin
            resp_sum_q  <= add_sum;
            resp_cout_q <= add_cout;
            resp_id_q   <= op_id_q;
        end
    end

    assign resp_valid = (state_q == StResp);
    assign resp_sum   = resp_sum_q;
    assign resp_cout  = resp_cout_q;
    assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: table vectors, hand-written corner
// sequences (contention, backpressure, reset mid-operation) and randomized
// traffic against a behavioural model. Honours ADDER_ARBITER_SUB_EN.
`timescale 1ns/1ps

module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_cin, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_cin, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id, resp_cout;
    logic [31:0] resp_sum;

    int checks   = 0;
    int failures = 0;
    logic m_prio;  // model: requester holding priority

    always #5 clk = ~clk;

    adder_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
`ifdef ADDER_ARBITER_SUB_EN
        .req0_sub   (req0_sub),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
`ifdef ADDER_ARBITER_SUB_EN
        .req1_sub   (req1_sub),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout)
    );

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {cout, sum} from the arithmetic definition of add / subtract.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [32:0] r;
        if (sub) begin
            r[31:0] = a - b;
            r[32]   = (a >= b);
        end else begin
            r = 33'(a) + 33'(b) + 33'(cin);
        end
        return r;
    endfunction

    task automatic wait_ready(input logic who, input string tag);
        int n = 0;
        logic got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            got = who ? req1_ready : req0_ready;
            n++;
        end
        check({tag, ".ready_seen"}, got, 1);
    endtask

    // Full transaction starting just after a rising edge with the FSM idle.
    task automatic transact(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                            input logic c0, input logic s0,
                            input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                            input logic c1, input logic s1,
                            input logic exp_id, input logic [32:0] exp_res, input string tag);
        int n = 0;
        logic got0 = 1'b0, got1 = 1'b0;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0; req0_sub = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1; req1_sub = s1;
        resp_ready = 1'b1;
        while (!(got0 || got1) && n < 20) begin
            @(negedge clk);
            got0 = req0_ready;
            got1 = req1_ready;
            n++;
        end
        check({tag, ".grant"}, {got1, got0}, exp_id ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        // Post-accept operand changes must not leak into the result.
        req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom);
        req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom);
        req0_sub = 1'($urandom); req1_sub = 1'($urandom);
        @(negedge clk);
        check({tag, ".exec_valid"}, resp_valid, 0);
        check({tag, ".exec_ready"}, {req1_ready, req0_ready}, 0);
        @(negedge clk);
        check({tag, ".resp_valid"}, resp_valid, 1);
        check({tag, ".resp_ready_lo"}, {req1_ready, req0_ready}, 0);
        check({tag, ".id"}, resp_id, exp_id);
        check({tag, ".sum"}, resp_sum, exp_res[31:0]);
        check({tag, ".cout"}, resp_cout, exp_res[32]);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, ".back_idle"}, resp_valid, 0);
        m_prio = ~exp_id;
    endtask

    initial begin
        int nresp;
        logic seen;
        logic exp_id;
        logic [32:0] res;
        logic v0, v1, s0, s1, c0, c1;
        logic [31:0] a0, b0, a1, b1;

        // Reset with both requesters already valid.
        rst_n = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_cin = 1'b0; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd200; req1_b = 32'd2; req1_cin = 1'b1; req1_sub = 1'b0;
        m_prio = 1'b0;
        #3;
        check("rst.ready", {req1_ready, req0_ready}, 0);
        check("rst.resp", {resp_valid, resp_id, resp_cout, resp_sum}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst.no_grant_before_edge", {req1_ready, req0_ready}, 0);

        // Contention: grants must alternate starting from PRIO_INIT.
        nresp = 0;
        for (int cyc = 0; cyc < 60 && nresp < 4; cyc++) begin
            if (cyc != 0) @(negedge clk);
            check("cont.one_ready", req0_ready & req1_ready, 0);
            if (resp_valid) begin
                check($sformatf("cont.id%0d", nresp), resp_id, m_prio);
                check($sformatf("cont.sum%0d", nresp), resp_sum, m_prio ? 32'd203 : 32'd101);
                m_prio = ~m_prio;
                nresp++;
            end
        end
        check("cont.count", nresp, 4);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure: result held for 5 cycles, both readys low meanwhile.
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_cin = 1'b0;
        wait_ready(1'b0, "bp");
        @(posedge clk); #1;
        resp_ready = 1'b0; req1_valid = 1'b1;
        req0_a = 32'hDEAD_BEEF;
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(resp_valid && resp_sum == 32'd7 && !resp_cout && !resp_id &&
                  !req0_ready && !req1_ready)) seen = 1'b1;
        end
        check("bp.stable5", seen, 0);
        check("bp.sum", resp_sum, 32'd7);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp.still_resp", resp_valid, 1);
        @(negedge clk);
        check("bp.idle_after", resp_valid, 0);
        check("bp.prio_passed", {req1_ready, req0_ready}, 2'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        // Reset during EXEC discards the operation.
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_cin = 1'b0;
        wait_ready(1'b1, "rexec");
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rexec.ready", {req1_ready, req0_ready}, 0);
        check("rexec.resp", {resp_valid, resp_id, resp_cout, resp_sum}, 0);
        @(posedge clk); #2;
        req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
        m_prio = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("rexec.no_resp", seen, 0);

        // Reset during RESP clears the held result at once.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd2; req0_cin = 1'b0;
        wait_ready(1'b0, "rresp");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rresp.before", {resp_valid, resp_cout, resp_sum}, {2'b11, 32'd1});
        rst_n = 1'b0;
        #1;
        check("rresp.cleared", {resp_valid, resp_id, resp_cout, resp_sum}, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("rresp.no_resp", seen, 0);
        @(posedge clk); #1;
        m_prio = 1'b0;

        // Table vectors, each from a single requester.
        vecs.push_back('{1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0});
        vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1});
`ifdef ADDER_ARBITER_SUB_EN
        vecs.push_back('{1'b0, 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{1'b0, 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1});
`endif
        foreach (vecs[i]) begin
            transact(!vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                     vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                     vecs[i].id, {vecs[i].cout, vecs[i].sum}, $sformatf("vec%0d", i));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 150; i++) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            a0 = $urandom; b0 = $urandom; c0 = 1'($urandom);
            a1 = $urandom; b1 = $urandom; c1 = 1'($urandom);
            if (i % 8 == 0) b0 = ~a0;
            s0 = 1'b0; s1 = 1'b0;
`ifdef ADDER_ARBITER_SUB_EN
            s0 = 1'($urandom); s1 = 1'($urandom);
`endif
            exp_id = (v0 && v1) ? m_prio : v1;
            res = exp_id ? model(a1, b1, c1, s1) : model(a0, b0, c0, s0);
            transact(v0, a0, b0, c0, s0, v1, a1, b1, c1, s1, exp_id, res,
                     $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
